// File: rtl/gpsa_pkg.sv
// Shared types and constants for the bit-serial g/p adder controller.
package gpsa_pkg;

  localparam int GPSA_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gpsa_state_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gp_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for gp_serial_adder_ctrl.
// GPSA_OVF_EN adds the signed-overflow flag ovf.
interface gp_serial_adder_ctrl_if import gpsa_pkg::*; #(
  parameter int WIDTH = GPSA_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             grp_g;
  logic             grp_p;
`ifdef GPSA_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef GPSA_OVF_EN
    input  ovf,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, grp_g, grp_p
  );

  modport slave (
`ifdef GPSA_OVF_EN
    output ovf,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, grp_g, grp_p
  );

endinterface

// File: rtl/gp_bit_cell.sv
// Single generate/propagate/half-sum bit cell shared with the parallel adder.
module gp_bit_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic g,
  output logic p,
  output logic h,
  output logic s,
  output logic co
);

  assign g  = x & y;
  assign p  = x | y;
  assign h  = p & ~g;
  assign s  = h ^ c;
  assign co = g | (p & c);

endmodule

// File: rtl/gp_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer, LSB first, with group G/P accumulation.
// Optional GPSA_OVF_EN adds a registered two's-complement overflow flag.
module gp_serial_adder_ctrl import gpsa_pkg::*; #(
  parameter int WIDTH = GPSA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  gp_serial_adder_ctrl_if.slave  bus
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  gpsa_state_e      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             g_q, g_d;
  logic             p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef GPSA_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_g, cell_p, cell_s, cell_co;
  logic unused_h;

  gp_bit_cell u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .c  (c_q),
    .g  (cell_g),
    .p  (cell_p),
    .h  (unused_h),
    .s  (cell_s),
    .co (cell_co)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
`ifdef GPSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          g_d     = 1'b0;
          p_d     = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sum_d = {cell_s, sum_q[WIDTH-1:1]};
        c_d   = cell_co;
        g_d   = cell_g | (cell_p & g_q);
        p_d   = p_q & cell_p;
        // The counter parks on the last index rather than wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
`ifdef GPSA_OVF_EN
          ovf_d   = c_q ^ cell_co;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef GPSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
`ifdef GPSA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = c_q;
  assign bus.grp_g     = g_q;
  assign bus.grp_p     = p_q;
`ifdef GPSA_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_gp_serial_adder_ctrl.sv
// Directed bench for gp_serial_adder_ctrl with an arithmetic reference model.
module tb_gp_serial_adder_ctrl;

  localparam int W    = 6;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gp_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  gp_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy, 2 result held.
  int m_phase, m_left;
  int m_sum, m_cout, m_g, m_p, m_ovf;
  int ai, bi, ci, full, sa, sb, sr;

  initial begin
    m_phase = 0;
    m_left  = 0;
    forever begin
      @(negedge clk);
      check("in_ready", int'(bus.in_ready), int'(m_phase == 0));
      check("out_valid", int'(bus.out_valid), int'(m_phase == 2));
      if (m_phase == 2) begin
        check("sum", int'(bus.sum), m_sum);
        check("cout", int'(bus.cout), m_cout);
        check("grp_g", int'(bus.grp_g), m_g);
        check("grp_p", int'(bus.grp_p), m_p);
`ifdef GPSA_OVF_EN
        check("ovf", int'(bus.ovf), m_ovf);
`endif
      end
      if (rst) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (bus.in_valid) begin
          ai     = int'(bus.a);
          bi     = int'(bus.b);
          ci     = int'(bus.cin);
          full   = ai + bi + ci;
          m_sum  = full & MASK;
          m_cout = full >> W;
          m_g    = (ai + bi) >> W;
          m_p    = int'((ai | bi) == MASK);
          sa     = (ai >= HALF) ? ai - (1 << W) : ai;
          sb     = (bi >= HALF) ? bi - (1 << W) : bi;
          sr     = sa + sb + ci;
          m_ovf  = int'((sr > HALF - 1) || (sr < -HALF));
          m_left = W;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else begin
        if (bus.out_ready) m_phase = 0;
      end
    end
  end

  task automatic start_op(input int ta, input int tb_v, input int tc);
    int k;
    @(posedge clk);
    #1;
    bus.a        = W'(ta);
    bus.b        = W'(tb_v);
    bus.cin      = tc[0];
    bus.in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 40);
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    if (!bus.out_valid) check("result_timeout", 0, 1);
  endtask

  task automatic consume();
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_sum", int'(bus.sum), 0);
    check("rst_grp_p", int'(bus.grp_p), 0);

    // 21 + 11: carry ripples into bit 5, no carry out.
    start_op(21, 11, 0);
    wait_result(lat);
    check("lat_21_11", lat, 7);
    check("sum_21_11", int'(bus.sum), 32);
    check("cout_21_11", int'(bus.cout), 0);
    check("g_21_11", int'(bus.grp_g), 0);
    check("p_21_11", int'(bus.grp_p), 0);
    consume();

    // 63 + 1: full-width propagate with generate at bit 0.
    start_op(63, 1, 0);
    wait_result(lat);
    check("sum_63_1", int'(bus.sum), 0);
    check("cout_63_1", int'(bus.cout), 1);
    check("g_63_1", int'(bus.grp_g), 1);
    check("p_63_1", int'(bus.grp_p), 1);
`ifdef GPSA_OVF_EN
    check("ovf_63_1", int'(bus.ovf), 0);
`endif
    consume();

    // A second request held through RUN/DONE with changed operands.
    @(posedge clk);
    #1;
    bus.a = 6'd0; bus.b = 6'd0; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    check("held_first_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.a = 6'd10; bus.b = 6'd20; bus.cin = 1'b0;
    wait_result(lat);
    check("sum_0_0_1", int'(bus.sum), 1);
    check("cout_0_0_1", int'(bus.cout), 0);
    check("g_0_0_1", int'(bus.grp_g), 0);
    check("p_0_0_1", int'(bus.grp_p), 0);
    consume();
    @(negedge clk);
    check("held_second_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(lat);
    check("lat_10_20", lat, 7);
    check("sum_10_20", int'(bus.sum), 30);
    consume();

    // Backpressure: 40 + 30 + 1 = 71 -> sum 7, carry out.
    start_op(40, 30, 1);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_sum", int'(bus.sum), 7);
      check("bp_cout", int'(bus.cout), 1);
      check("bp_grp_g", int'(bus.grp_g), 1);
    end
    consume();
    @(negedge clk);
    check("bp_idle_after", int'(bus.in_ready), 1);

    // Reset on the third RUN cycle aborts the operation.
    start_op(45, 18, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_sum", int'(bus.sum), 0);
    check("abort_cout", int'(bus.cout), 0);
    check("abort_grp_g", int'(bus.grp_g), 0);
    check("abort_grp_p", int'(bus.grp_p), 0);
    start_op(2, 3, 0);
    wait_result(lat);
    check("sum_2_3", int'(bus.sum), 5);
    consume();

`ifdef GPSA_OVF_EN
    start_op(31, 1, 0);
    wait_result(lat);
    check("sum_31_1", int'(bus.sum), 32);
    check("ovf_31_1", int'(bus.ovf), 1);
    consume();
    start_op(32, 63, 0);
    wait_result(lat);
    check("sum_32_63", int'(bus.sum), 31);
    check("cout_32_63", int'(bus.cout), 1);
    check("ovf_32_63", int'(bus.ovf), 1);
    consume();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
